// File: rtl/fir_fold_pkg.sv
// Shared types and default constants for the folded-FIR input adapter.
// The state typedef, the default geometry and the saturating counter helper
// live here so the top, the FIFO and the bench all agree on them.
package fir_fold_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_PRIME = 2'd1,
      ST_RUN   = 2'd2
   } state_t;

   localparam int FOLD_DEF      = 29;
   localparam int OUT_PHASE_DEF = 2;
   localparam int W_DEF         = 16;
   localparam int DEPTH_DEF     = 4;

   // Saturating increment for 32-bit event counters.
   function automatic logic [31:0] sat_inc32(input logic [31:0] v);
      return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
   endfunction

endpackage

// File: rtl/fir_fold_adapter_if.sv
// Bus bundle between the upstream producer / folded FIR and the adapter.
// master: the side that produces samples and FIR results (bench or system).
// slave : the adapter itself.
interface fir_fold_adapter_if
   import fir_fold_pkg::*;
#(
   parameter int W = W_DEF
);
   logic                en;
   logic                s_valid;
   logic signed [W-1:0] s_data;
   logic                s_ready;
   logic                fir_en;
   logic signed [W-1:0] fir_din;
   logic signed [W-1:0] fir_dout;
   logic                m_valid;
   logic signed [W-1:0] m_data;
   logic                underrun;

   modport master (
      output en, s_valid, s_data, fir_dout,
      input  s_ready, fir_en, fir_din, m_valid, m_data, underrun
   );

   modport slave (
      input  en, s_valid, s_data, fir_dout,
      output s_ready, fir_en, fir_din, m_valid, m_data, underrun
   );
endinterface

// File: rtl/fir_fold_fifo.sv
// Small synchronous FIFO with registered pointers and an occupancy count.
// A push into a full FIFO and a pop from an empty FIFO are both ignored, so
// a simultaneous push/pop when full drops the push and when empty drops the pop.
module fir_fold_fifo
   import fir_fold_pkg::*;
#(
   parameter  int W     = W_DEF,
   parameter  int DEPTH = DEPTH_DEF,
   localparam int AW    = $clog2(DEPTH),
   localparam int CW    = AW + 1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                push_i,
   input  logic signed [W-1:0] data_i,
   input  logic                pop_i,
   output logic signed [W-1:0] head_o,
   output logic [CW-1:0]       count_o
);
   logic signed [W-1:0] mem_q [DEPTH];
   logic [AW-1:0]       wr_ptr_q;
   logic [AW-1:0]       rd_ptr_q;
   logic [CW-1:0]       count_q;
   logic [CW-1:0]       count_d;
   logic                push_ok;
   logic                pop_ok;

   // Qualify requests against occupancy and work out the next count.
   always_comb begin
      push_ok = push_i && (count_q != CW'(DEPTH));
      pop_ok  = pop_i && (count_q != '0);
      count_d = count_q;
      if (push_ok && !pop_ok)
         count_d = count_q + CW'(1);
      else if (pop_ok && !push_ok)
         count_d = count_q - CW'(1);
   end

   // Pointer and count registers; reset wins over any transfer.
   always_ff @(posedge clk) begin
      if (!rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (pop_ok)  rd_ptr_q <= rd_ptr_q + AW'(1);
         count_q <= count_d;
      end
   end

   // Storage array is data only and carries no reset.
   always_ff @(posedge clk) begin
      if (rst && push_ok) mem_q[wr_ptr_q] <= data_i;
   end

   assign head_o  = mem_q[rd_ptr_q];
   assign count_o = count_q;
endmodule

// File: rtl/fir_fold_adapter.sv
// Feeds a time-folded FIR: one sample is launched per FOLD-cycle frame (at
// phase 0) from an input FIFO, and the FIR result is captured at OUT_PHASE of
// every frame after the first. Optional event counters are compiled in with
// the macro FIR_FOLD_ADAPTER_STATS_EN.
module fir_fold_adapter
   import fir_fold_pkg::*;
#(
   parameter  int FOLD      = FOLD_DEF,
   parameter  int OUT_PHASE = OUT_PHASE_DEF,
   parameter  int W         = W_DEF,
   parameter  int DEPTH     = DEPTH_DEF,
   localparam int PW        = (FOLD > 1) ? $clog2(FOLD) : 1,
   localparam int CW        = $clog2(DEPTH) + 1
) (
   input  logic               clk,
   input  logic               rst,
   fir_fold_adapter_if.slave  bus
`ifdef FIR_FOLD_ADAPTER_STATS_EN
   ,
   output logic [31:0]        launch_cnt,
   output logic [31:0]        underrun_cnt
`endif
);
   state_t              state_q;
   logic [PW-1:0]       phase_q;
   logic [PW-1:0]       phase_d;
   logic                fir_en_q;
   logic signed [W-1:0] fir_din_q;
   logic                m_valid_q;
   logic signed [W-1:0] m_data_q;
   logic                underrun_q;
   logic signed [W-1:0] fifo_head;
   logic [CW-1:0]       fifo_count;
   logic                fifo_empty;
   logic                active;
   logic                launch;
   logic                pop;
   logic                empty_launch;
   logic                capture;
   logic                frame_end;

   fir_fold_fifo #(.W(W), .DEPTH(DEPTH)) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (bus.s_valid),
      .data_i  (bus.s_data),
      .pop_i   (pop),
      .head_o  (fifo_head),
      .count_o (fifo_count)
   );

   // Frame timing decode: launch slot, capture slot and phase wrap.
   always_comb begin
      fifo_empty   = (fifo_count == '0);
      active       = (state_q != ST_IDLE) && bus.en;
      launch       = active && (phase_q == '0);
      pop          = launch && !fifo_empty;
      empty_launch = launch && fifo_empty;
      capture      = bus.en && (state_q == ST_RUN) && (phase_q == PW'(OUT_PHASE));
      frame_end    = (phase_q == PW'(FOLD - 1));
      phase_d      = frame_end ? '0 : phase_q + PW'(1);
   end

   // Frame FSM with its registered control outputs.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q    <= ST_IDLE;
         phase_q    <= '0;
         fir_en_q   <= 1'b0;
         m_valid_q  <= 1'b0;
         underrun_q <= 1'b0;
      end else begin
         fir_en_q   <= (state_q != ST_IDLE);
         m_valid_q  <= capture;
         underrun_q <= underrun_q | empty_launch;
         case (state_q)
            ST_IDLE: begin
               phase_q <= '0;
               if (bus.en) state_q <= ST_PRIME;
            end
            ST_PRIME, ST_RUN: begin
               if (!bus.en) begin
                  // Partial frame is abandoned; next start re-primes.
                  state_q <= ST_IDLE;
                  phase_q <= '0;
               end else begin
                  phase_q <= phase_d;
                  if (state_q == ST_PRIME && frame_end) state_q <= ST_RUN;
               end
            end
            default: begin
               state_q <= ST_IDLE;
               phase_q <= '0;
            end
         endcase
      end
   end

   // Data registers: launched sample (zero outside the slot) and captured result.
   always_ff @(posedge clk) begin
      if (!rst) begin
         fir_din_q <= '0;
         m_data_q  <= '0;
      end else begin
         fir_din_q <= pop ? fifo_head : '0;
         if (capture) m_data_q <= bus.fir_dout;
      end
   end

`ifdef FIR_FOLD_ADAPTER_STATS_EN
   logic [31:0] launch_cnt_q;
   logic [31:0] underrun_cnt_q;

   // Saturating counts of launched samples and empty launch slots.
   always_ff @(posedge clk) begin
      if (!rst) begin
         launch_cnt_q   <= '0;
         underrun_cnt_q <= '0;
      end else begin
         if (pop)          launch_cnt_q   <= sat_inc32(launch_cnt_q);
         if (empty_launch) underrun_cnt_q <= sat_inc32(underrun_cnt_q);
      end
   end

   assign launch_cnt   = launch_cnt_q;
   assign underrun_cnt = underrun_cnt_q;
`endif

   assign bus.s_ready  = (fifo_count != CW'(DEPTH));
   assign bus.fir_en   = fir_en_q;
   assign bus.fir_din  = fir_din_q;
   assign bus.m_valid  = m_valid_q;
   assign bus.m_data   = m_data_q;
   assign bus.underrun = underrun_q;
endmodule

// File: tb/tb_fir_fold_adapter.sv
// Scoreboard bench for fir_fold_adapter. The stimulus process drives one
// cycle at a time and pushes the expected post-edge outputs, computed from a
// frame-arithmetic reference model (run length, k mod FOLD, a sample queue).
// A negedge monitor pops and compares. The FIR is stood in by a one-cycle
// echo of fir_din.
module tb_fir_fold_adapter;
   import fir_fold_pkg::*;

   localparam int FOLD      = 29;
   localparam int OUT_PHASE = 2;
   localparam int W         = 16;
   localparam int DEPTH     = 4;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   fir_fold_adapter_if #(.W(W)) bus ();

`ifdef FIR_FOLD_ADAPTER_STATS_EN
   logic [31:0] launch_cnt;
   logic [31:0] underrun_cnt;
`endif

   fir_fold_adapter #(.FOLD(FOLD), .OUT_PHASE(OUT_PHASE), .W(W), .DEPTH(DEPTH)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
`ifdef FIR_FOLD_ADAPTER_STATS_EN
      ,
      .launch_cnt   (launch_cnt),
      .underrun_cnt (underrun_cnt)
`endif
   );

   // FIR stand-in: result equals the input delayed by one cycle.
   logic signed [W-1:0] fir_dly = '0;
   always @(posedge clk) fir_dly <= bus.fir_din;
   assign bus.fir_dout = fir_dly;

   typedef struct {
      logic                fir_en;
      logic signed [W-1:0] fir_din;
      logic                m_valid;
      logic signed [W-1:0] m_data;
      logic                s_ready;
      logic                underrun;
      logic [31:0]         n_launch;
      logic [31:0]         n_empty;
   } exp_t;

   exp_t exp_q[$];

   // Reference model state.
   logic signed [W-1:0] mq[$];
   int                  run_cnt   = 0;
   logic                und       = 1'b0;
   logic signed [W-1:0] frame_val = '0;
   logic signed [W-1:0] md        = '0;
   logic [31:0]         n_launch  = '0;
   logic [31:0]         n_empty   = '0;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   int t11      = -1;
   int t22      = -1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %h required %h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // Drive one cycle, predict the outputs after the coming edge, then advance.
   task automatic step(input logic r, input logic e, input logic sv,
                       input logic signed [W-1:0] sd, output logic accepted);
      exp_t x;
      logic ready;
      int   k;
      rst         = r;
      bus.en      = e;
      bus.s_valid = sv;
      bus.s_data  = sd;
      accepted    = 1'b0;
      if (!r) begin
         mq.delete();
         run_cnt   = 0;
         und       = 1'b0;
         md        = '0;
         frame_val = '0;
         n_launch  = '0;
         n_empty   = '0;
         x.fir_en  = 1'b0;
         x.fir_din = '0;
         x.m_valid = 1'b0;
         x.s_ready = 1'b1;
      end else begin
         ready     = (mq.size() < DEPTH);
         x.fir_en  = (run_cnt >= 1);
         x.fir_din = '0;
         x.m_valid = 1'b0;
         if (e && run_cnt >= 1) begin
            k = run_cnt - 1;
            if (k % FOLD == 0) begin
               if (mq.size() > 0) begin
                  frame_val = mq.pop_front();
                  x.fir_din = frame_val;
                  n_launch++;
               end else begin
                  frame_val = '0;
                  und       = 1'b1;
                  n_empty++;
               end
            end
            if (k % FOLD == OUT_PHASE && k / FOLD >= 1) begin
               x.m_valid = 1'b1;
               md        = frame_val;
            end
         end
         if (sv && ready) begin
            mq.push_back(sd);
            accepted = 1'b1;
         end
         run_cnt   = e ? run_cnt + 1 : 0;
         x.s_ready = (mq.size() < DEPTH);
      end
      x.m_data   = md;
      x.underrun = und;
      x.n_launch = n_launch;
      x.n_empty  = n_empty;
      exp_q.push_back(x);
      @(posedge clk);
      #1;
      cyc++;
   endtask

   // Monitor: compare every presented cycle against the scoreboard head.
   always @(negedge clk) begin
      exp_t x;
      if (exp_q.size() > 0) begin
         x = exp_q.pop_front();
         chk("fir_en",   {31'd0, bus.fir_en},   {31'd0, x.fir_en});
         chk("fir_din",  32'(bus.fir_din),      32'(x.fir_din));
         chk("m_valid",  {31'd0, bus.m_valid},  {31'd0, x.m_valid});
         chk("m_data",   32'(bus.m_data),       32'(x.m_data));
         chk("s_ready",  {31'd0, bus.s_ready},  {31'd0, x.s_ready});
         chk("underrun", {31'd0, bus.underrun}, {31'd0, x.underrun});
`ifdef FIR_FOLD_ADAPTER_STATS_EN
         chk("launch_cnt",   launch_cnt,   x.n_launch);
         chk("underrun_cnt", underrun_cnt, x.n_empty);
`endif
         if (bus.fir_din == 16'sh0011 && t11 < 0) t11 = cyc;
         if (bus.fir_din == 16'sh0022 && t22 < 0) t22 = cyc;
      end
   end

   function automatic logic signed [W-1:0] rnd_sample();
      return W'($urandom_range(1, 65535));
   endfunction

   initial begin
      logic acc;
      logic en_r;
      logic sv_r;
      logic signed [W-1:0] pend;
      rst         = 1'b0;
      bus.en      = 1'b0;
      bus.s_valid = 1'b0;
      bus.s_data  = '0;

      // Reset held with traffic present: nothing may be accepted or launched.
      for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b1, rnd_sample(), acc);

      // Three samples, then three frames of running.
      step(1'b1, 1'b0, 1'b1, 16'sh0011, acc);
      step(1'b1, 1'b0, 1'b1, 16'sh0022, acc);
      step(1'b1, 1'b0, 1'b1, 16'sh0033, acc);
      for (int i = 0; i < 3 * FOLD + 6; i++) step(1'b1, 1'b1, 1'b0, '0, acc);
      for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, '0, acc);

      // Overfill with en low; fifth sample waits for the first launch.
      for (int i = 0; i < 2; i++) step(1'b0, 1'b0, 1'b0, '0, acc);
      for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b1, 16'sh0100 + W'(i), acc);
      pend = 16'sh0105;
      for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b1, pend, acc);
      acc = 1'b0;
      for (int i = 0; i < 2 * FOLD && !acc; i++) step(1'b1, 1'b1, 1'b1, pend, acc);
      chk("fifth_accepted", {31'd0, acc}, 32'd1);
      for (int i = 0; i < 4 * FOLD; i++) step(1'b1, 1'b1, 1'b0, '0, acc);

      // Empty launch slot sets underrun; later pushes must not clear it.
      for (int i = 0; i < 2; i++) step(1'b0, 1'b0, 1'b0, '0, acc);
      for (int i = 0; i < FOLD + 5; i++) step(1'b1, 1'b1, 1'b0, '0, acc);
      step(1'b1, 1'b1, 1'b1, 16'sh0a0a, acc);
      step(1'b1, 1'b1, 1'b1, 16'sh0b0b, acc);
      for (int i = 0; i < 2 * FOLD; i++) step(1'b1, 1'b1, 1'b0, '0, acc);

      // Drop en at phase 10 of a running frame, then restart.
      for (int i = 0; i < 2; i++) step(1'b0, 1'b0, 1'b0, '0, acc);
      for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b1, 16'sh0200 + W'(i), acc);
      for (int i = 0; i < 1 + FOLD + 10; i++) step(1'b1, 1'b1, 1'b0, '0, acc);
      for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, '0, acc);
      for (int i = 0; i < 2 * FOLD + 6; i++) step(1'b1, 1'b1, 1'b0, '0, acc);

      // Randomised traffic with occasional en toggles and resets.
      step(1'b0, 1'b0, 1'b0, '0, acc);
      en_r = 1'b1;
      sv_r = 1'b0;
      pend = rnd_sample();
      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(0, 63) == 0) en_r = ~en_r;
         if (!sv_r && $urandom_range(0, 15) == 0) begin
            sv_r = 1'b1;
            pend = rnd_sample();
         end
         if ($urandom_range(0, 499) == 0) begin
            step(1'b0, en_r, sv_r, pend, acc);
            sv_r = 1'b0;
         end else begin
            step(1'b1, en_r, sv_r, pend, acc);
            if (acc) sv_r = 1'b0;
         end
      end
      for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, '0, acc);

      @(negedge clk);
      #1;
      chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
      chk("launch_gap", 32'(t22 - t11), 32'(FOLD));
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
